// File: rtl/mem_lsu_initiator.sv
// mem_lsu_initiator: splits byte-addressed core loads/stores into word accesses with strobes.
module mem_lsu_initiator #(
  parameter int ADDR_WIDTH     = 20,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH+1:0] req_addr,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err,
  output logic                  mem_valid,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [3:0]            mem_wstrb,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata,
  input  logic                  mem_ready
);
  typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;
  state_t state_q, state_d;
  logic req_ready_q, req_ready_d, rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
  logic mem_valid_q, mem_valid_d, we_q, we_d, sgn_q, sgn_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d, mem_wdata_q, mem_wdata_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d, word_q, word_d;
  logic [3:0] mem_wstrb_q, mem_wstrb_d;
  logic [1:0] size_q, size_d, off_q, off_d;
  logic [2:0] lanes_hi_q, lanes_hi_d;
  logic [31:0] wd_hi_q, wd_hi_d, lo_q, lo_d, cnt_q, cnt_d;
  logic [6:0] in_lanes;
  logic [63:0] in_wd;
  logic [31:0] x, ld;
  logic timeout;
  assign in_lanes = (req_size == 2'd0 ? 7'h01 : req_size == 2'd1 ? 7'h03 : 7'h0f) << req_addr[1:0];
  assign in_wd = {32'b0, req_wdata} << {req_addr[1:0], 3'b0};
  // in ACC1 the live read data is the high word; otherwise it is the low word and hi is zero
  assign x = 32'({(state_q == ACC1 ? mem_rdata : 32'b0), (state_q == ACC1 ? lo_q : mem_rdata)} >> {off_q, 3'b0});
  assign ld = size_q == 2'd0 ? {{24{sgn_q & x[7]}}, x[7:0]} :
              size_q == 2'd1 ? {{16{sgn_q & x[15]}}, x[15:0]} : x;
  assign timeout = TIMEOUT_CYCLES != 0 && !mem_ready && cnt_q + 32'd1 == 32'(TIMEOUT_CYCLES);
  always_comb begin
    state_d     = state_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    mem_valid_d = mem_valid_q;
    mem_addr_d  = mem_addr_q;
    mem_wstrb_d = mem_wstrb_q;
    mem_wdata_d = mem_wdata_q;
    we_d        = we_q;
    sgn_d       = sgn_q;
    size_d      = size_q;
    off_d       = off_q;
    lanes_hi_d  = lanes_hi_q;
    word_d      = word_q;
    wd_hi_d     = wd_hi_q;
    lo_d        = lo_q;
    cnt_d       = cnt_q;
    case (state_q)
      IDLE: if (req_valid) begin
        req_ready_d = 1'b0;
        we_d        = req_we;
        sgn_d       = req_signed;
        size_d      = req_size;
        off_d       = req_addr[1:0];
        lanes_hi_d  = in_lanes[6:4];
        word_d      = req_addr[ADDR_WIDTH+1:2];
        wd_hi_d     = in_wd[63:32];
        rsp_rdata_d = 32'b0;
        rsp_err_d   = req_size == 2'd3;
        rsp_valid_d = req_size == 2'd3;
        state_d     = req_size == 2'd3 ? RESP : ACC0;
        if (req_size != 2'd3) begin
          mem_valid_d = 1'b1;
          mem_addr_d  = req_addr[ADDR_WIDTH+1:2];
          mem_wstrb_d = req_we ? in_lanes[3:0] : 4'b0;
          mem_wdata_d = in_wd[31:0];
          cnt_d       = 32'b0;
        end
      end
      ACC0, ACC1: if (mem_ready) begin
        if (state_q == ACC0 && lanes_hi_q != 3'b0) begin
          state_d     = ACC1;
          lo_d        = mem_rdata;
          mem_addr_d  = word_q + ADDR_WIDTH'(1);
          mem_wstrb_d = we_q ? {1'b0, lanes_hi_q} : 4'b0;
          mem_wdata_d = wd_hi_q;
          cnt_d       = 32'b0;
        end else begin
          state_d     = RESP;
          mem_valid_d = 1'b0;
          mem_wstrb_d = 4'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = we_q ? 32'b0 : ld;
        end
      end else if (timeout) begin
        state_d     = RESP;
        mem_valid_d = 1'b0;
        mem_wstrb_d = 4'b0;
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b1;
        rsp_rdata_d = 32'b0;
      end else begin
        cnt_d = cnt_q + 32'd1;
      end
      default: begin
        state_d     = IDLE;
        req_ready_d = 1'b1;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 32'b0;
      mem_valid_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wstrb_q <= 4'b0;
      mem_wdata_q <= 32'b0;
      we_q        <= 1'b0;
      sgn_q       <= 1'b0;
      size_q      <= 2'b0;
      off_q       <= 2'b0;
      lanes_hi_q  <= 3'b0;
      word_q      <= '0;
      wd_hi_q     <= 32'b0;
      lo_q        <= 32'b0;
      cnt_q       <= 32'b0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      mem_valid_q <= mem_valid_d;
      mem_addr_q  <= mem_addr_d;
      mem_wstrb_q <= mem_wstrb_d;
      mem_wdata_q <= mem_wdata_d;
      we_q        <= we_d;
      sgn_q       <= sgn_d;
      size_q      <= size_d;
      off_q       <= off_d;
      lanes_hi_q  <= lanes_hi_d;
      word_q      <= word_d;
      wd_hi_q     <= wd_hi_d;
      lo_q        <= lo_d;
      cnt_q       <= cnt_d;
    end
  end
  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign mem_valid = mem_valid_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wstrb = mem_wstrb_q;
  assign mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_mem_lsu_initiator.sv
// tb_mem_lsu_initiator: byte-level reference memory model plus directed load/store vectors.
module tb_mem_lsu_initiator;
  localparam int AW = 20;
  localparam int TO = 8;
  logic clk = 1'b0, rst_n = 1'b0;
  logic req_valid = 1'b0, req_we = 1'b0, req_signed = 1'b0;
  logic [AW+1:0] req_addr = '0;
  logic [1:0] req_size = 2'b0;
  logic [31:0] req_wdata = 32'b0;
  logic req_ready, rsp_valid, rsp_err, mem_valid, mem_ready;
  logic [31:0] rsp_rdata, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;
  logic [3:0] mem_wstrb;
  always #5 clk = ~clk;
  mem_lsu_initiator #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_size(req_size), .req_signed(req_signed), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .mem_valid(mem_valid),
    .mem_addr(mem_addr), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready));
  int total = 0, bad = 0;
  int waits = 0;
  bit stall = 1'b0;
  int wcnt;
  bit ram_init = 1'b0, ref_init = 1'b0;
  logic [31:0] ram [1024];
  logic [7:0] ref_b [4096];
  logic [55:0] exp_acc [$];
  logic [32:0] exp_rsp [$];
  logic [55:0] acc_log [$];
  function automatic void chk(string nm, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endfunction
  // responder: on-chip RAM with a programmable number of wait cycles per access
  assign mem_ready = mem_valid && !stall && (wcnt >= waits);
  assign mem_rdata = ram[mem_addr[9:0]];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt <= 0;
      if (!ram_init) begin
        for (int i = 0; i < 1024; i++) ram[i] <= 32'b0;
        ram_init <= 1'b1;
      end
    end else if (mem_valid && mem_ready) begin
      wcnt <= 0;
      for (int l = 0; l < 4; l++) if (mem_wstrb[l]) ram[mem_addr[9:0]][8*l+:8] <= mem_wdata[8*l+:8];
      acc_log.push_back({mem_addr, mem_wstrb, mem_wdata});
    end else if (mem_valid) begin
      wcnt <= wcnt + 1;
    end
  end
  // compare process: every active mem/rsp cycle against the model's expectation queues
  always @(negedge clk) begin
    logic [55:0] e;
    logic [32:0] r;
    if (!rst_n) begin
      if (!ref_init) begin
        for (int i = 0; i < 4096; i++) ref_b[i] = 8'h00;
        ref_init = 1'b1;
      end
    end else begin
      if (mem_valid) begin
        if (exp_acc.size() == 0) begin
          total++; bad++;
          $display("FAIL spurious_mem_valid: got addr %h strb %h, required no access", mem_addr, mem_wstrb);
        end else begin
          e = exp_acc[0];
          chk("mem_addr", 32'(mem_addr), 32'(e[55:36]));
          chk("mem_wstrb", 32'(mem_wstrb), 32'(e[35:32]));
          chk("mem_wdata", mem_wdata, e[31:0]);
          if (mem_ready) begin
            for (int l = 0; l < 4; l++) if (e[32+l]) ref_b[{e[45:36], 2'(l)}] = e[8*l+:8];
            void'(exp_acc.pop_front());
          end
        end
      end
      if (rsp_valid) begin
        if (exp_rsp.size() == 0) begin
          total++; bad++;
          $display("FAIL spurious_rsp_valid: got rdata %h err %b, required no response", rsp_rdata, rsp_err);
        end else begin
          r = exp_rsp.pop_front();
          chk("rsp_err", 32'(rsp_err), 32'(r[32]));
          chk("rsp_rdata", rsp_rdata, r[31:0]);
        end
      end
    end
  end
  // mode 0: normal, 1: responder stalls (timeout error), 2: aborted by reset (no response)
  task automatic start_req(input bit we, input logic [21:0] a, input logic [1:0] sz, input bit sg,
                           input logic [31:0] wd, input int mode, output int nacc);
    int n;
    logic [21:0] last, idx;
    logic [19:0] w;
    logic [3:0] s;
    logic [31:0] d, v;
    n = sz == 2'd0 ? 1 : sz == 2'd1 ? 2 : 4;
    nacc = 0;
    if (sz != 2'd3) begin
      last = a + 22'(n - 1);
      for (int k = 0; k < 2; k++) begin
        if (k == 1 && last[21:2] == a[21:2]) break;
        w = k == 0 ? a[21:2] : last[21:2];
        s = 4'b0;
        d = 32'b0;
        for (int l = 0; l < 4; l++) begin
          idx = {w, 2'(l)} - a;
          if (idx < 22'd4) d[8*l+:8] = wd[8*int'(idx)+:8];
          if (we && idx < 22'(n)) s[l] = 1'b1;
        end
        exp_acc.push_back({w, s, d});
        nacc++;
      end
    end
    v = 32'b0;
    for (int i = 0; i < n; i++) v[8*i+:8] = ref_b[12'(a + 22'(i))];
    if (sg && v[8*n-1]) for (int i = n; i < 4; i++) v[8*i+:8] = 8'hFF;
    if (mode != 2) exp_rsp.push_back((sz == 2'd3 || mode == 1) ? {1'b1, 32'b0} : {1'b0, we ? 32'b0 : v});
    @(negedge clk);
    for (int k = 0; k < 20 && !req_ready; k++) @(negedge clk);
    if (!req_ready) begin
      $display("FAIL req_ready_wait: req_ready still 0 after 20 cycles, required 1");
      $fatal(1, "initiator never became ready");
    end
    req_valid = 1'b1; req_we = we; req_addr = a; req_size = sz; req_signed = sg; req_wdata = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask
  task automatic finish_req(output int lat, output int mv, output logic err, output logic [31:0] rd);
    lat = 0; mv = 0; err = 1'b0; rd = 32'b0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (mem_valid) mv++;
      if (rsp_valid) begin
        lat = k; err = rsp_err; rd = rsp_rdata;
        break;
      end
    end
    if (lat == 0) begin
      total++; bad++;
      $display("FAIL rsp_wait: no rsp_valid within 60 cycles, required one");
    end
  endtask
  task automatic op(input bit we, input logic [21:0] a, input logic [1:0] sz, input bit sg,
                    input logic [31:0] wd, input int wt, input int mode,
                    output int lat, output int mv, output logic err, output logic [31:0] rd);
    int nacc;
    waits = wt;
    start_req(we, a, sz, sg, wd, mode, nacc);
    finish_req(lat, mv, err, rd);
    if (mode == 0) chk("latency", 32'(lat), 32'(1 + nacc * (1 + wt)));
  endtask
  function automatic void chk_log(string nm, int i, logic [19:0] ad, logic [3:0] st, logic [31:0] dt);
    logic [55:0] l;
    l = i < acc_log.size() ? acc_log[i] : 56'b0;
    chk({nm, "_addr"}, 32'(l[55:36]), 32'(ad));
    chk({nm, "_strb"}, 32'(l[35:32]), 32'(st));
    chk({nm, "_data"}, l[31:0], dt);
  endfunction
  typedef struct {
    bit we; logic [21:0] a; logic [1:0] sz; bit sg; logic [31:0] wd; int wt;
  } vec_t;
  vec_t vecs [10];
  initial begin
    int lat, mv, base;
    logic err;
    logic [31:0] rd;
    vecs[0] = '{1'b1, 22'h205, 2'd0, 1'b0, 32'h000000A5, 0};
    vecs[1] = '{1'b1, 22'h207, 2'd1, 1'b0, 32'h00009234, 1};
    vecs[2] = '{1'b1, 22'h209, 2'd2, 1'b0, 32'h0BADCAFE, 0};
    vecs[3] = '{1'b0, 22'h205, 2'd0, 1'b1, 32'h0, 0};
    vecs[4] = '{1'b0, 22'h207, 2'd1, 1'b0, 32'h0, 0};
    vecs[5] = '{1'b0, 22'h207, 2'd1, 1'b1, 32'h0, 2};
    vecs[6] = '{1'b0, 22'h209, 2'd2, 1'b0, 32'h0, 1};
    vecs[7] = '{1'b0, 22'h206, 2'd2, 1'b0, 32'h0, 2};
    vecs[8] = '{1'b0, 22'h20B, 2'd1, 1'b1, 32'h0, 1};
    vecs[9] = '{1'b1, 22'h20A, 2'd0, 1'b0, 32'h11223380, 0};
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_mem_valid", 32'(mem_valid), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    rst_n = 1'b1;
    base = acc_log.size();
    op(1'b1, 22'h100, 2'd2, 1'b0, 32'hDEADBEEF, 0, 0, lat, mv, err, rd);
    chk_log("st_word", base, 20'h40, 4'hF, 32'hDEADBEEF);
    op(1'b0, 22'h100, 2'd2, 1'b0, 32'h0, 0, 0, lat, mv, err, rd);
    chk("ld_word_lat", 32'(lat), 32'd2);
    chk("ld_word_val", rd, 32'hDEADBEEF);
    op(1'b1, 22'h100, 2'd2, 1'b0, 32'h80FF0000, 0, 0, lat, mv, err, rd);
    op(1'b0, 22'h103, 2'd0, 1'b1, 32'h0, 0, 0, lat, mv, err, rd);
    chk("lb_signed", rd, 32'hFFFFFF80);
    op(1'b0, 22'h103, 2'd0, 1'b0, 32'h0, 0, 0, lat, mv, err, rd);
    chk("lb_unsigned", rd, 32'h00000080);
    op(1'b0, 22'h102, 2'd1, 1'b1, 32'h0, 0, 0, lat, mv, err, rd);
    chk("lh_signed", rd, 32'hFFFF80FF);
    base = acc_log.size();
    op(1'b1, 22'h102, 2'd2, 1'b0, 32'h11223344, 0, 0, lat, mv, err, rd);
    chk("split_st_lat", 32'(lat), 32'd3);
    chk_log("split_st0", base, 20'h40, 4'hC, 32'h33440000);
    chk_log("split_st1", base + 1, 20'h41, 4'h3, 32'h00001122);
    op(1'b0, 22'h102, 2'd2, 1'b0, 32'h0, 0, 0, lat, mv, err, rd);
    chk("split_ld_lat", 32'(lat), 32'd3);
    chk("split_ld_val", rd, 32'h11223344);
    base = acc_log.size();
    op(1'b1, 22'h3FFFFF, 2'd1, 1'b0, 32'h0000ABCD, 0, 0, lat, mv, err, rd);
    chk_log("wrap_st0", base, 20'hFFFFF, 4'h8, 32'hCD000000);
    chk_log("wrap_st1", base + 1, 20'h00000, 4'h1, 32'h000000AB);
    op(1'b0, 22'h3FFFFF, 2'd1, 1'b1, 32'h0, 0, 0, lat, mv, err, rd);
    chk("wrap_ld_val", rd, 32'hFFFFABCD);
    op(1'b0, 22'h102, 2'd2, 1'b0, 32'h0, 2, 0, lat, mv, err, rd);
    chk("wait_split_lat", 32'(lat), 32'd7);
    foreach (vecs[i]) op(vecs[i].we, vecs[i].a, vecs[i].sz, vecs[i].sg, vecs[i].wd, vecs[i].wt, 0, lat, mv, err, rd);
    stall = 1'b1;
    op(1'b0, 22'h102, 2'd2, 1'b0, 32'h0, 0, 1, lat, mv, err, rd);
    chk("timeout_mv_cycles", 32'(mv), 32'd8);
    chk("timeout_lat", 32'(lat), 32'd9);
    chk("timeout_err", 32'(err), 32'd1);
    chk("timeout_rdata", rd, 32'd0);
    exp_acc.delete();
    stall = 1'b0;
    op(1'b0, 22'h100, 2'd2, 1'b0, 32'h0, 0, 0, lat, mv, err, rd);
    chk("post_timeout_ld", rd, 32'h33440000);
    op(1'b0, 22'h100, 2'd3, 1'b0, 32'h0, 0, 0, lat, mv, err, rd);
    chk("illegal_err", 32'(err), 32'd1);
    chk("illegal_mv_cycles", 32'(mv), 32'd0);
    chk("illegal_lat", 32'(lat), 32'd1);
    op(1'b1, 22'h2FC, 2'd2, 1'b0, 32'h00000000, 0, 0, lat, mv, err, rd);
    op(1'b1, 22'h300, 2'd2, 1'b0, 32'hCAFEF00D, 0, 0, lat, mv, err, rd);
    waits = 3;
    start_req(1'b1, 22'h2FE, 2'd2, 1'b0, 32'h55667788, 2, lat);
    for (int k = 0; k < 40 && !(mem_valid && mem_addr == 20'hC0); k++) @(negedge clk);
    chk("abort_reached_acc1", 32'(mem_addr), 32'hC0);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_mem_valid_async", 32'(mem_valid), 32'd0);
    chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    exp_acc.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("abort_req_ready", 32'(req_ready), 32'd1);
    repeat (3) @(negedge clk);
    op(1'b0, 22'h2FC, 2'd2, 1'b0, 32'h0, 0, 0, lat, mv, err, rd);
    chk("abort_first_word", rd, 32'h77880000);
    op(1'b0, 22'h300, 2'd2, 1'b0, 32'h0, 0, 0, lat, mv, err, rd);
    chk("abort_second_word", rd, 32'hCAFEF00D);
    chk("abort_ram_second", ram[10'hC0], 32'hCAFEF00D);
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end
endmodule
